object_slot_scheduler: RTL

OBJECT_SLOT_SCHEDULER -- requirements
Module: object_slot_scheduler

---
 rtl/object_slot_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/object_slot_scheduler.sv
// Object slot scheduler: periodically spawns objects into the lowest free slot
// and retires them when they are sliced or leave the screen.
module object_slot_scheduler #(
  parameter int N_SLOTS      = 4,
  parameter int SPAWN_PERIOD = 60,
  parameter int X_MIN        = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_en,
  input  logic               frame_tick,
  input  logic [N_SLOTS-1:0] oob_flag,
  input  logic [N_SLOTS-1:0] cut_flag,
  input  logic               spawn_ready,
  output logic [N_SLOTS-1:0] slot_active,
  output logic               spawn_valid,
  output logic [1:0]         spawn_slot,
  output logic [9:0]         spawn_x,
  output logic               miss_pulse,
  output logic [2:0]         free_count
);

  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SEARCH, SPAWN} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   frame_cnt, frame_cnt_next;
  logic [9:0]         lfsr;
  logic [1:0]         spawn_slot_next;
  logic [9:0]         spawn_x_next;
  logic               accept;
  logic               free_found;
  logic [1:0]         free_idx;
  logic [2:0]         active_cnt;
  logic [N_SLOTS-1:0] arm;
  logic [N_SLOTS-1:0] set_mask;
  logic [N_SLOTS-1:0] release_mask;
  logic [N_SLOTS-1:0] miss_mask;

  assign spawn_valid = (state == SPAWN);

  // Lowest-index inactive slot wins: scan from the top so the last hit is the lowest.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    active_cnt = 3'd0;
    for (int i = 0; i < N_SLOTS; i++) begin
      active_cnt = active_cnt + 3'(slot_active[i]);
    end
  end

  always_comb begin
    state_next      = state;
    frame_cnt_next  = frame_cnt;
    spawn_slot_next = spawn_slot;
    spawn_x_next    = spawn_x;
    accept          = 1'b0;
    case (state)
      IDLE: begin
        state_next     = WAIT;
        frame_cnt_next = '0;
      end
      WAIT: begin
        if (frame_tick) begin
          if (frame_cnt == CNT_W'(SPAWN_PERIOD - 1)) begin
            frame_cnt_next = '0;
            state_next     = SEARCH;
          end else begin
            frame_cnt_next = frame_cnt + 1'b1;
          end
        end
      end
      SEARCH: begin
        if (free_found) begin
          spawn_slot_next = free_idx;
          spawn_x_next    = 10'(X_MIN) + {1'b0, lfsr[8:0]};
          state_next      = SPAWN;
        end else begin
          state_next = WAIT;
        end
      end
      SPAWN: begin
        if (spawn_ready) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
    // Disabling the game overrides everything, including an in-flight handshake.
    if (!game_en) begin
      state_next = IDLE;
      accept     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      spawn_slot <= 2'd0;
      spawn_x    <= 10'd0;
      lfsr       <= 10'h2A5;
      miss_pulse <= 1'b0;
      free_count <= 3'(N_SLOTS);
    end else begin
      state      <= state_next;
      frame_cnt  <= frame_cnt_next;
      spawn_slot <= spawn_slot_next;
      spawn_x    <= spawn_x_next;
      lfsr       <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      miss_pulse <= |miss_mask;
      free_count <= 3'(N_SLOTS) - active_cnt;
    end
  end

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      assign set_mask[gi]     = accept && (spawn_slot == 2'(gi));
      assign release_mask[gi] = slot_active[gi] && (cut_flag[gi] || (oob_flag[gi] && arm[gi]));
      assign miss_mask[gi]    = slot_active[gi] && oob_flag[gi] && arm[gi] && !cut_flag[gi];

      // The arm bit keeps a stale out-of-bound flag from killing a freshly spawned object.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_active[gi] <= 1'b0;
          arm[gi]         <= 1'b0;
        end else begin
          if (set_mask[gi]) begin
            slot_active[gi] <= 1'b1;
            arm[gi]         <= 1'b0;
          end else begin
            if (release_mask[gi]) begin
              slot_active[gi] <= 1'b0;
            end
            if (frame_tick && slot_active[gi]) begin
              arm[gi] <= 1'b1;
            end
          end
        end
      end
    end
  endgenerate

endmodule
